regfile_wb_sched: RTL and testbench

Write-back scheduler for the 32×32 integer register file. It arbitrates the file's single write port between the in-order pipeline write-back and a long-latency unit (mul/div, cache-miss load). It also keeps a scoreboard of destination registers owned by in-flight long-latency ops, which decode queries to stall on RAW/WAW hazards. It sits between WB/long-latency units and the register file's `wregs_Enable`/`wregsAddr`/`wdata` inputs.

---
 rtl/regfile_wb_sched_if.sv | 50 +++++
 rtl/regfile_wb_sched.sv | 113 +++++++++++
 tb/tb_regfile_wb_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sched_if.sv
// Write-back scheduler bus: pipeline/long-latency write requests, issue tracking,
// decode scoreboard queries and the register-file write port.
interface regfile_wb_sched_if #(
  parameter int DATA_W = 32
);
  logic              pipe_valid;
  logic [4:0]        pipe_addr;
  logic [DATA_W-1:0] pipe_data;

  logic              lu_valid;
  logic              lu_ready;
  logic [4:0]        lu_addr;
  logic [DATA_W-1:0] lu_data;

  logic              iss_valid;
  logic [4:0]        iss_addr;

  logic [4:0]        q_addr1;
  logic [4:0]        q_addr2;
  logic              q_busy1;
  logic              q_busy2;

  logic              stall_req;

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    output iss_valid, iss_addr,
    output q_addr1, q_addr2,
    input  q_busy1, q_busy2,
    input  stall_req,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    input  iss_valid, iss_addr,
    input  q_addr1, q_addr2,
    output q_busy1, q_busy2,
    output stall_req,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Register-file write-port arbiter (pipe over queued long-latency results) with a busy scoreboard.
// Latency: pipe 1 cycle, queued result 2 cycles; lu_ready = !full, stall_req asks the pipe to yield.
module regfile_wb_sched #(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);
  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [4:0]        q_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              empty, full, push, pop;

  logic              win_vld, win_lu;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;

  logic              rf_we_q, out_lu;
  logic [4:0]        rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [31:0]       busy, busy_nxt;
  logic [2:0]        starve, starve_nxt;
  logic              stall_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push  = bus.lu_valid && !full;
  assign pop   = !bus.pipe_valid && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_mem[wr_ptr[PTR_W-1:0]] <= bus.lu_addr;
      q_data_mem[wr_ptr[PTR_W-1:0]] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    win_vld  = bus.pipe_valid || !empty;
    win_lu   = !bus.pipe_valid;
    win_addr = bus.pipe_valid ? bus.pipe_addr : q_addr_mem[rd_ptr[PTR_W-1:0]];
    win_data = bus.pipe_valid ? bus.pipe_data : q_data_mem[rd_ptr[PTR_W-1:0]];
  end

  // Writes to r0 still consume their slot but never assert the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      out_lu     <= 1'b0;
    end else if (win_vld) begin
      rf_we_q    <= (win_addr != 5'd0);
      rf_waddr_q <= win_addr;
      rf_wdata_q <= win_data;
      out_lu     <= win_lu;
    end else begin
      rf_we_q    <= 1'b0;
      out_lu     <= 1'b0;
    end
  end

  // Clear lands on the edge the file commits; a same-address issue overrides it.
  always_comb begin
    busy_nxt = busy;
    if (rf_we_q && out_lu) busy_nxt[rf_waddr_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_addr != 5'd0)) busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_comb begin
    starve_nxt = '0;
    if (bus.pipe_valid && !empty)
      starve_nxt = (starve == 3'd7) ? starve : starve + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      starve  <= '0;
      stall_q <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      starve  <= starve_nxt;
      stall_q <= (starve_nxt >= LIMIT);
    end
  end

  assign bus.lu_ready  = !full;
  assign bus.q_busy1   = (bus.q_addr1 != 5'd0) && busy[bus.q_addr1];
  assign bus.q_busy2   = (bus.q_addr2 != 5'd0) && busy[bus.q_addr2];
  assign bus.stall_req = stall_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table of per-cycle stimulus/expectations
// plus a hand-written mid-operation asynchronous reset sequence.
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_sched_if #(.DATA_W(32)) bus ();

  regfile_wb_sched #(
    .DATA_W(32),
    .FIFO_DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk_ad;
    logic        rdy;
    logic        b1;
    logic        b2;
    logic        st;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input int pv, input int pa, input int pd,
                              input int lv, input int la, input int ld,
                              input int iv, input int ia, input int q1, input int q2,
                              input int we, input int wa, input int wd, input int cad,
                              input int rdy, input int b1, input int b2, input int st);
    vec_t v;
    v.pv = pv[0]; v.pa = pa[4:0]; v.pd = pd;
    v.lv = lv[0]; v.la = la[4:0]; v.ld = ld;
    v.iv = iv[0]; v.ia = ia[4:0]; v.q1 = q1[4:0]; v.q2 = q2[4:0];
    v.we = we[0]; v.wa = wa[4:0]; v.wd = wd; v.chk_ad = cad[0];
    v.rdy = rdy[0]; v.b1 = b1[0]; v.b2 = b2[0]; v.st = st[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.pipe_valid = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.lu_valid   = 1'b0; bus.lu_addr   = '0; bus.lu_data   = '0;
    bus.iss_valid  = 1'b0; bus.iss_addr  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: pipe v/a/d | lu v/a/d | iss v/a | q1 q2 || we wa wd chk_ad | rdy b1 b2 stall
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 7, 9,  1, 5, 32'hDEADBEEF, 1,  1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h11111111, 0, 0, 0,      0, 0, 7, 9,  0, 0, 0,            0,  1, 0, 0, 0);
    vecs[2]  = mk(1, 3, 32'hA5A5A5A5, 0, 0, 0,      0, 0, 7, 9,  1, 3, 32'hA5A5A5A5, 1,  1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,            0, 0, 0,      1, 7, 7, 9,  0, 3, 32'hA5A5A5A5, 1,  1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0,            1, 7, 'h1234, 1, 9, 7, 9,  0, 3, 32'hA5A5A5A5, 1,  1, 1, 1, 0);
    vecs[5]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 7, 9,  1, 7, 'h1234,       1,  1, 1, 1, 0);
    vecs[6]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 7, 9,  0, 7, 'h1234,       1,  1, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0,            1, 9, 'h99,   0, 0, 7, 9,  0, 7, 'h1234,       1,  1, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 7, 9,  1, 9, 'h99,         1,  1, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0,            0, 0, 0,      1, 9, 7, 9,  0, 9, 'h99,         1,  1, 0, 1, 0);
    vecs[10] = mk(1, 1, 'h101,        1, 10, 'hAAAA, 0, 0, 7, 9, 1, 1, 'h101,        1,  1, 0, 1, 0);
    vecs[11] = mk(1, 2, 'h102,        1, 11, 'hBBBB, 0, 0, 7, 9, 1, 2, 'h102,        1,  0, 0, 1, 0);
    vecs[12] = mk(1, 3, 'h103,        0, 0, 0,      0, 0, 7, 9,  1, 3, 'h103,        1,  0, 0, 1, 0);
    vecs[13] = mk(1, 4, 'h104,        0, 0, 0,      0, 0, 7, 9,  1, 4, 'h104,        1,  0, 0, 1, 0);
    vecs[14] = mk(1, 5, 'h105,        0, 0, 0,      0, 0, 7, 9,  1, 5, 'h105,        1,  0, 0, 1, 1);
    vecs[15] = mk(1, 6, 'h106,        0, 0, 0,      0, 0, 7, 9,  1, 6, 'h106,        1,  0, 0, 1, 1);
    vecs[16] = mk(0, 0, 0,            0, 0, 0,      0, 0, 7, 9,  1, 10, 'hAAAA,      1,  1, 0, 1, 0);
    vecs[17] = mk(0, 0, 0,            0, 0, 0,      0, 0, 7, 9,  1, 11, 'hBBBB,      1,  1, 0, 1, 0);
    vecs[18] = mk(0, 0, 0,            0, 0, 0,      0, 0, 7, 9,  0, 11, 'hBBBB,      1,  1, 0, 1, 0);
    vecs[19] = mk(1, 9, 'h55,         0, 0, 0,      1, 0, 0, 9,  1, 9, 'h55,         1,  1, 0, 1, 0);

    drive_idle();
    bus.q_addr1 = 5'd7;
    bus.q_addr2 = 5'd9;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rf_we",     32'(bus.rf_we),     32'd0);
    chk("reset rf_waddr",  32'(bus.rf_waddr),  32'd0);
    chk("reset rf_wdata",  bus.rf_wdata,       32'd0);
    chk("reset lu_ready",  32'(bus.lu_ready),  32'd1);
    chk("reset stall_req", 32'(bus.stall_req), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.pipe_valid = vecs[i].pv; bus.pipe_addr = vecs[i].pa; bus.pipe_data = vecs[i].pd;
      bus.lu_valid   = vecs[i].lv; bus.lu_addr   = vecs[i].la; bus.lu_data   = vecs[i].ld;
      bus.iss_valid  = vecs[i].iv; bus.iss_addr  = vecs[i].ia;
      bus.q_addr1    = vecs[i].q1; bus.q_addr2   = vecs[i].q2;
      @(posedge clk);
      #1;
      n_vec++;
      chk($sformatf("v%0d rf_we", i), 32'(bus.rf_we), 32'(vecs[i].we));
      if (vecs[i].chk_ad) begin
        chk($sformatf("v%0d rf_waddr", i), 32'(bus.rf_waddr), 32'(vecs[i].wa));
        chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vecs[i].wd);
      end
      chk($sformatf("v%0d lu_ready", i),  32'(bus.lu_ready),  32'(vecs[i].rdy));
      chk($sformatf("v%0d q_busy1", i),   32'(bus.q_busy1),   32'(vecs[i].b1));
      chk($sformatf("v%0d q_busy2", i),   32'(bus.q_busy2),   32'(vecs[i].b2));
      chk($sformatf("v%0d stall_req", i), 32'(bus.stall_req), 32'(vecs[i].st));
    end

    // Mid-operation reset: fill the queue behind a busy pipe, mark r12/r13 busy, reach stall.
    bus.q_addr1 = 5'd12;
    bus.q_addr2 = 5'd13;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_idle();
      bus.pipe_valid = 1'b1;
      bus.pipe_addr  = 5'(k + 1);
      bus.pipe_data  = 32'(k + 32'h200);
      if (k < 2) begin
        bus.lu_valid  = 1'b1;
        bus.lu_addr   = (k == 0) ? 5'd12 : 5'd13;
        bus.lu_data   = 32'(k + 32'hC00);
        bus.iss_valid = 1'b1;
        bus.iss_addr  = (k == 0) ? 5'd12 : 5'd13;
      end
      @(posedge clk);
      #1;
      n_vec++;
    end
    chk("pre-reset rf_we",     32'(bus.rf_we),     32'd1);
    chk("pre-reset lu_ready",  32'(bus.lu_ready),  32'd0);
    chk("pre-reset q_busy1",   32'(bus.q_busy1),   32'd1);
    chk("pre-reset q_busy2",   32'(bus.q_busy2),   32'd1);
    chk("pre-reset stall_req", 32'(bus.stall_req), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async reset rf_we",     32'(bus.rf_we),     32'd0);
    chk("async reset rf_waddr",  32'(bus.rf_waddr),  32'd0);
    chk("async reset rf_wdata",  bus.rf_wdata,       32'd0);
    chk("async reset lu_ready",  32'(bus.lu_ready),  32'd1);
    chk("async reset q_busy1",   32'(bus.q_busy1),   32'd0);
    chk("async reset q_busy2",   32'(bus.q_busy2),   32'd0);
    chk("async reset stall_req", 32'(bus.stall_req), 32'd0);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      chk($sformatf("post-reset c%0d rf_we", k),    32'(bus.rf_we),    32'd0);
      chk($sformatf("post-reset c%0d lu_ready", k), 32'(bus.lu_ready), 32'd1);
      chk($sformatf("post-reset c%0d q_busy1", k),  32'(bus.q_busy1),  32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
